div_8bit_seq: RTL

Sequential 8-bit unsigned restoring divider, the inverse datapath to the carry-save multiplier array. It accepts a dividend and divisor on a start pulse and retires one quotient bit per clock. It presents quotient, remainder and a divide-by-zero flag with a one-cycle done strobe. It sits beside the multiplier in the arithmetic core and is driven by the same operand-select logic.

---
 rtl/arith_pkg.sv | 13 +
 rtl/fa.sv | 13 +
 rtl/sub_9bit.sv | 30 +++
 rtl/div_8bit_seq.sv | 118 +++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic core: datapath widths and the divider FSM encoding.
package arith_pkg;

    localparam int DIV_W     = 8;
    localparam int DIV_STEPS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/fa.sv
// One-bit full adder cell, the building block of the ripple arithmetic in this core.
module fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/sub_9bit.sv
// Ripple subtractor a - b formed as a + ~b + 1 over a chain of fa cells.
// borrow is high when b > a (no carry out of the top cell).
module sub_9bit #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_cell
            fa u_fa (
                .a  (a[gi]),
                .b  (~b[gi]),
                .ci (carry[gi]),
                .s  (diff[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    assign borrow = ~carry[W];

endmodule

// File: rtl/div_8bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, registered results
// with a one-cycle done strobe and a divide-by-zero flag.
module div_8bit_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH:0]   pr_reg;
    logic [WIDTH-1:0] q_sr_reg;
    logic [WIDTH-1:0] d_reg;
    logic             dz_pend_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dz_reg;
    logic             done_reg;
    logic             busy_reg;

    logic [WIDTH:0]   t_next;
    logic [WIDTH:0]   diff_next;
    logic             borrow_next;
    logic [WIDTH:0]   pr_next;
    logic [WIDTH-1:0] q_sr_next;
    logic             last_step;

    // Shift the next dividend bit into the partial remainder; pr never exceeds
    // the divisor, so the bit shifted out of the top is always zero.
    assign t_next = (pr_reg << 1) | {{WIDTH{1'b0}}, q_sr_reg[WIDTH-1]};

    sub_9bit #(
        .W (WIDTH + 1)
    ) u_sub (
        .a      (t_next),
        .b      ({1'b0, d_reg}),
        .diff   (diff_next),
        .borrow (borrow_next)
    );

    // Restore on borrow; the quotient bit is the inverse of the borrow.
    assign pr_next   = borrow_next ? t_next : diff_next;
    assign q_sr_next = {q_sr_reg[WIDTH-2:0], ~borrow_next};
    assign last_step = (count_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            pr_reg        <= '0;
            q_sr_reg      <= '0;
            d_reg         <= '0;
            dz_pend_reg   <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_reg        <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        q_sr_reg    <= dividend;
                        d_reg       <= divisor;
                        pr_reg      <= '0;
                        count_reg   <= '0;
                        dz_pend_reg <= (divisor == '0);
                        busy_reg    <= 1'b1;
                        state_reg   <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    pr_reg    <= pr_next;
                    q_sr_reg  <= q_sr_next;
                    count_reg <= count_reg + 1'b1;
                    // Results move to the output registers only on completion so
                    // they hold the previous answer for the whole run.
                    if (last_step) begin
                        quotient_reg  <= q_sr_next;
                        remainder_reg <= pr_next[WIDTH-1:0];
                        dz_reg        <= dz_pend_reg;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_reg != RUN);
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign dz        = dz_reg;

endmodule
